// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
// Cell geometry, attribute layout, cursor line range and the per-pixel stage record.
package vga_text_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int LATENCY = 5;

  localparam int VRAM_AW = 12;
  localparam int FONT_AW = 12;

  // Character RAM word: [7:0] code, [11:8] foreground, [15:12] background.
  localparam int ATTR_CHAR_LSB = 0;
  localparam int ATTR_CHAR_W   = 8;
  localparam int ATTR_FG_LSB   = 8;
  localparam int ATTR_BG_LSB   = 12;
  localparam int ATTR_COLOR_W  = 4;

  localparam int CURSOR_LINE_FIRST = 14;
  localparam int CURSOR_LINE_LAST  = 15;

  typedef struct packed {
    logic                    vis;
    logic                    hit;
    logic [2:0]              px;
    logic [3:0]              line;
    logic [ATTR_COLOR_W-1:0] fg;
    logic [ATTR_COLOR_W-1:0] bg;
  } pix_stage_t;

  // Glyph bit 7 is the leftmost pixel; a cursor hit swaps foreground and background.
  function automatic logic [ATTR_COLOR_W-1:0] pick_color(
    input logic [7:0]              glyph,
    input logic [2:0]              px,
    input logic                    invert,
    input logic [ATTR_COLOR_W-1:0] fg,
    input logic [ATTR_COLOR_W-1:0] bg
  );
    logic on;
    on = glyph[3'd7 - px] ^ invert;
    return on ? fg : bg;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a configurable reset value per bit.
// Keeps the sync/visible flags aligned with the pixel pipeline.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  // NOTE: these stages are individual flops rather than a RAM, so every one is
  // reset; non-blocking assignments make each stage take its neighbour's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: cell address -> char RAM -> font ROM -> IRGB colour,
// with a blinking cursor overlay and syncs delayed to match the 5-clock latency.
module text_renderer #(
  parameter int COUNT_W = 10,
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int BLINK_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               visible_in,
  input  logic [COUNT_W-1:0] x_in,
  input  logic [COUNT_W-1:0] y_in,
  input  logic               cursor_en,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic [11:0]        vram_addr,
  input  logic [15:0]        vram_data,
  output logic [11:0]        font_addr,
  input  logic [7:0]         font_data,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               visible_out,
  output logic [3:0]         color
);

  import vga_text_pkg::*;

  localparam int PX_W   = $clog2(CHAR_W);
  localparam int LINE_W = $clog2(CHAR_H);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  logic [PX_W-1:0]   px;
  logic [LINE_W-1:0] line;
  logic [COL_W-1:0]  cell_col;
  logic [ROW_W-1:0]  cell_row;
  logic              cursor_line;
  logic              cursor_hit;
  logic              unused_y;

  assign px       = x_in[PX_W-1:0];
  assign cell_col = x_in[PX_W +: COL_W];
  assign line     = y_in[LINE_W-1:0];
  assign cell_row = y_in[LINE_W +: ROW_W];
  assign unused_y = ^y_in[COUNT_W-1:LINE_W+ROW_W];

  logic [BLINK_W-1:0] blink;
  logic               vs_prev;
  logic               armed;

  assign cursor_line = (int'(line) >= CURSOR_LINE_FIRST) && (int'(line) <= CURSOR_LINE_LAST);
  assign cursor_hit  = cursor_en && (7'(cell_col) == cursor_col) && (5'(cell_row) == cursor_row)
                       && cursor_line && blink[BLINK_W-1];

  pix_stage_t s1, s2, s3, s4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= '0;
      vs_prev   <= 1'b1;
      armed     <= 1'b0;
      vram_addr <= '0;
      font_addr <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      color     <= '0;
    end else begin
      // The first edge after reset release never counts as a vsync fall.
      vs_prev <= vsync_in;
      armed   <= 1'b1;
      if (armed && vs_prev && !vsync_in) blink <= blink + 1'b1;

      // Stage 1: cell address plus the per-pixel context that rides with it.
      vram_addr <= VRAM_AW'(cell_row * COLS + cell_col);
      s1 <= '{vis: visible_in, hit: cursor_hit, px: px, line: line, fg: '0, bg: '0};

      // Stage 2: char RAM is reading; context just follows.
      s2 <= s1;

      // Stage 3: capture attributes and address the glyph row.
      font_addr <= {vram_data[ATTR_CHAR_LSB +: ATTR_CHAR_W], s2.line};
      s3 <= '{vis: s2.vis, hit: s2.hit, px: s2.px, line: s2.line,
              fg: vram_data[ATTR_FG_LSB +: ATTR_COLOR_W],
              bg: vram_data[ATTR_BG_LSB +: ATTR_COLOR_W]};

      // Stage 4: font ROM is reading.
      s4 <= s3;

      color <= s4.vis ? pick_color(font_data, s4.px, s4.hit, s4.fg, s4.bg) : '0;
    end
  end

  // Syncs idle high, visible idles low.
  logic [2:0] sync_q;

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (LATENCY),
    .RESET_VAL (3'b110)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hsync_in, vsync_in, visible_in}),
    .q     (sync_q)
  );

  assign hsync_out   = sync_q[2];
  assign vsync_out   = sync_q[1];
  assign visible_out = sync_q[0];

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: table-driven pixel stream plus hand-written
// reset, addressing and cursor-blink sequences against small memory models.
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in, visible_in;
  logic [9:0]  x_in, y_in;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] vram_addr;
  logic [15:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        hsync_out, vsync_out, visible_out;
  logic [3:0]  color;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .visible_in  (visible_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .cursor_en   (cursor_en),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .visible_out (visible_out),
    .color       (color)
  );

  // Synchronous-read memory models.
  logic [15:0] vram_mem [4096];
  logic [7:0]  font_mem [4096];

  always @(posedge clk) begin
    vram_data <= vram_mem[vram_addr];
    font_data <= font_mem[font_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       hs;
    logic       vs;
    logic [3:0] exp_color;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int x, input int y, input logic vis, input logic hs,
                         input logic vs, input logic [3:0] c);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.vis = vis; v.hs = hs; v.vs = vs; v.exp_color = c;
    vecs.push_back(v);
  endtask

  task automatic drive_px(input int x, input int y, input logic vis);
    x_in = 10'(x); y_in = 10'(y); visible_in = vis;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync_in = 1'b0;
      @(negedge clk); vsync_in = 1'b1;
    end
  endtask

  task automatic pixel_check(input string name, input int x, input int y, input logic [3:0] exp);
    @(negedge clk);
    drive_px(x, y, 1'b1);
    repeat (5) @(negedge clk);
    check(name, 32'(color), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vram_mem[i] = '0;
      font_mem[i] = '0;
    end
    vram_mem[0]    = 16'h1F41;
    vram_mem[1]    = 16'h5A00;
    vram_mem[80]   = 16'h3741;
    vram_mem[2399] = 16'h2C41;
    font_mem[12'h410] = 8'h81;
    font_mem[12'h41F] = 8'hF0;

    rst_n = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; visible_in = 1'b0;
    x_in = '0; y_in = '0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

    // Reset held with random inputs: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_color",   32'(color), 0);
      check("rst_hsync",   32'(hsync_out), 1);
      check("rst_vsync",   32'(vsync_out), 1);
      check("rst_visible", 32'(visible_out), 0);
      check("rst_vram",    32'(vram_addr), 0);
      check("rst_font",    32'(font_addr), 0);
      hsync_in   = 1'($urandom_range(0, 1));
      vsync_in   = 1'($urandom_range(0, 1));
      visible_in = 1'($urandom_range(0, 1));
      x_in       = 10'($urandom_range(0, 639));
      y_in       = 10'($urandom_range(0, 479));
      cursor_en  = 1'($urandom_range(0, 1));
    end

    // Release: four reset-content outputs, then the input appears on the fifth.
    @(negedge clk);
    cursor_en = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b1;
    drive_px(0, 0, 1'b1);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("rel_hsync",   32'(hsync_out), (k < 5) ? 1 : 0);
      check("rel_visible", 32'(visible_out), (k < 5) ? 0 : 1);
      check("rel_color",   32'(color), (k < 5) ? 0 : 32'hF);
    end

    // Streamed pixels: glyph row, neighbour cells, last cell, blanking.
    add_vec(0,   0,   1, 1, 1, 4'hF);
    add_vec(1,   0,   1, 0, 1, 4'h1);
    add_vec(2,   0,   1, 0, 0, 4'h1);
    add_vec(3,   0,   1, 1, 0, 4'h1);
    add_vec(4,   0,   1, 0, 1, 4'h1);
    add_vec(5,   0,   1, 1, 1, 4'h1);
    add_vec(6,   0,   1, 0, 0, 4'h1);
    add_vec(7,   0,   1, 1, 1, 4'hF);
    add_vec(8,   0,   1, 1, 0, 4'h5);
    add_vec(0,   16,  1, 0, 1, 4'h7);
    add_vec(0,   17,  1, 1, 1, 4'h3);
    add_vec(632, 464, 1, 0, 0, 4'hC);
    add_vec(635, 464, 1, 1, 0, 4'h2);
    add_vec(0,   0,   0, 0, 1, 4'h0);
    add_vec(7,   0,   1, 1, 1, 4'hF);
    add_vec(639, 479, 1, 0, 0, 4'h2);

    for (int n = 0; n < vecs.size() + 5; n++) begin
      @(negedge clk);
      if (n >= 5) begin
        check("tbl_color",   32'(color),       32'(vecs[n-5].exp_color));
        check("tbl_hsync",   32'(hsync_out),   32'(vecs[n-5].hs));
        check("tbl_vsync",   32'(vsync_out),   32'(vecs[n-5].vs));
        check("tbl_visible", 32'(visible_out), 32'(vecs[n-5].vis));
      end
      if (n < vecs.size()) begin
        drive_px(int'(vecs[n].x), int'(vecs[n].y), vecs[n].vis);
        hsync_in = vecs[n].hs;
        vsync_in = vecs[n].vs;
      end else begin
        drive_px(0, 0, 1'b0);
        hsync_in = 1'b1; vsync_in = 1'b1;
      end
    end

    // Addressing of the last cell and its glyph row.
    @(negedge clk);
    drive_px(632, 464, 1'b1);
    @(negedge clk);
    check("addr_last_cell", 32'(vram_addr), 2399);
    repeat (2) @(negedge clk);
    check("font_addr_41_0", 32'(font_addr), 32'h410);
    @(negedge clk);
    drive_px(8, 16, 1'b1);
    @(negedge clk);
    check("addr_cell_1_1", 32'(vram_addr), 81);

    // Cursor blink on cell (0,0).
    reset_dut();
    cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
    pixel_check("cur_blink0",     0, 15, 4'hF);
    vsync_pulses(15);
    pixel_check("cur_blink15",    0, 15, 4'hF);
    vsync_pulses(1);
    pixel_check("cur_blink16",    0, 15, 4'h1);
    pixel_check("cur_line14",     0, 14, 4'hF);
    pixel_check("cur_line13",     0, 13, 4'h1);
    pixel_check("cur_other_cell", 8, 15, 4'h5);
    cursor_en = 1'b0;
    pixel_check("cur_disabled",   0, 15, 4'hF);
    cursor_en = 1'b1;
    vsync_pulses(16);
    pixel_check("cur_blink32",    0, 15, 4'hF);

    // vsync already low at reset release must not count as an edge.
    @(negedge clk);
    rst_n = 1'b0; vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vsync_in = 1'b1;
    vsync_pulses(15);
    pixel_check("rel_vs_15",      0, 15, 4'hF);
    vsync_pulses(1);
    pixel_check("rel_vs_16",      0, 15, 4'h1);

    // Mid-frame asynchronous reset.
    cursor_en = 1'b0;
    @(negedge clk);
    drive_px(0, 0, 1'b1);
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_pre_color", 32'(color), 32'hF);
    check("mid_pre_hsync", 32'(hsync_out), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_color",   32'(color), 0);
    check("mid_hsync",   32'(hsync_out), 1);
    check("mid_vsync",   32'(vsync_out), 1);
    check("mid_visible", 32'(visible_out), 0);
    check("mid_vram",    32'(vram_addr), 0);
    check("mid_font",    32'(font_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("mid_rel_hsync", 32'(hsync_out), (k < 5) ? 1 : 0);
      check("mid_rel_vsync", 32'(vsync_out), (k < 5) ? 1 : 0);
      check("mid_rel_color", 32'(color), (k < 5) ? 0 : 32'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
